// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared constants and the sequencer state encoding for the OV7670 camera
// configuration path.
//   OV7670_CMD_END     : table terminator word
//   OV7670_CMD_SWRESET : COM7 soft-reset write, followed by a settle delay
//   OV7670_I2C_ID      : SCCB write address of the sensor (used by the sender)
// ---------------------------------------------------------------------------
package ov7670_pkg;

    localparam logic [15:0] OV7670_CMD_END     = 16'hFFFF;
    localparam logic [15:0] OV7670_CMD_SWRESET = 16'h1280;
    localparam logic [7:0]  OV7670_I2C_ID      = 8'h42;

    typedef enum logic [2:0] {
        POWERUP = 3'd0,
        FETCH   = 3'd1,
        SEND    = 3'd2,
        DELAY   = 3'd3,
        DONE    = 3'd4
    } ov7670_state_e;

endpackage

// File: rtl/ov7670_config_rom.sv
// ---------------------------------------------------------------------------
// ov7670_config_rom
// Combinational {register, value} command table for the OV7670.
// Ports:
//   addr [INDEX_W-1:0] in  : table index
//   data [15:0]        out : command word; 16'hFFFF for unlisted addresses
// ROM_SEL picks the table: 0 = sensor setup (RGB565), 1 = short terminated
// bring-up table, 2 = four-entry table without a terminator (for exercising
// the index-wrap stop on a 2-bit index).
// ---------------------------------------------------------------------------
module ov7670_config_rom
    import ov7670_pkg::*;
#(
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned ROM_SEL = 0
) (
    input  logic [INDEX_W-1:0] addr,
    output logic [15:0]        data
);

    logic [31:0] addr_s;

    // Table lookup; anything not listed reads back as the terminator.
    always_comb begin
        addr_s = 32'(addr);
        data   = OV7670_CMD_END;
        if (ROM_SEL == 32'd1) begin
            case (addr_s)
                32'd0:   data = OV7670_CMD_SWRESET;
                32'd1:   data = 16'h1204;
                32'd2:   data = 16'h4010;
                default: data = OV7670_CMD_END;
            endcase
        end else if (ROM_SEL == 32'd2) begin
            case (addr_s)
                32'd0:   data = OV7670_CMD_SWRESET;
                32'd1:   data = 16'h1204;
                32'd2:   data = 16'h4010;
                32'd3:   data = 16'h3A04;
                default: data = OV7670_CMD_END;
            endcase
        end else begin
            case (addr_s)
                32'd0:   data = OV7670_CMD_SWRESET; // COM7: soft reset
                32'd1:   data = 16'h1204;           // COM7: RGB output
                32'd2:   data = 16'h1180;           // CLKRC: direct input clock
                32'd3:   data = 16'h0C00;           // COM3: no scaling
                32'd4:   data = 16'h3E00;           // COM14: no PCLK divide
                32'd5:   data = 16'h8C00;           // RGB444 off
                32'd6:   data = 16'h0400;           // COM1: no CCIR656
                32'd7:   data = 16'h40D0;           // COM15: RGB565, full range
                32'd8:   data = 16'h3A04;           // TSLB: output sequence
                32'd9:   data = 16'h1438;           // COM9: AGC ceiling
                32'd10:  data = 16'h4FB3;           // MTX1
                32'd11:  data = 16'h50B3;           // MTX2
                32'd12:  data = 16'h5100;           // MTX3
                32'd13:  data = 16'h523D;           // MTX4
                32'd14:  data = 16'h53A7;           // MTX5
                32'd15:  data = 16'h54E4;           // MTX6
                32'd16:  data = 16'h589E;           // MTXS
                32'd17:  data = 16'h3DC0;           // COM13: gamma, UV auto
                default: data = OV7670_CMD_END;
            endcase
        end
    end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// ---------------------------------------------------------------------------
// ov7670_config_sequencer
// Walks the OV7670 command table and hands each {register, value} word to
// the I2C sender with a send/taken handshake. Waits POWERUP_CYCLES after
// reset before the first word, waits SWRESET_CYCLES after the COM7 soft
// reset is taken, and stops at the 16'hFFFF terminator or at the last index.
// Ports:
//   clk     in  : system clock
//   reset   in  : synchronous, active-high reset
//   resend  in  : re-run the table (only honoured when done)
//   taken   in  : sender has latched the current command
//   command out : {register, value} word presented to the sender
//   send    out : command valid
//   busy    out : low only when the table has completed
//   done    out : configuration complete
//   index   out : current table index
// ---------------------------------------------------------------------------
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 50000,
    parameter int unsigned SWRESET_CYCLES = 50000,
    parameter int unsigned INDEX_W        = 8,
    parameter int unsigned ROM_SEL        = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               resend,
    input  logic               taken,
    output logic [15:0]        command,
    output logic               send,
    output logic               busy,
    output logic               done,
    output logic [INDEX_W-1:0] index
);

    localparam logic [23:0]        PU_LAST   = 24'(POWERUP_CYCLES - 32'd1);
    localparam logic [23:0]        SR_LAST   = 24'(SWRESET_CYCLES - 32'd1);
    localparam logic [INDEX_W-1:0] IDX_MAX   = '1;
    localparam logic [INDEX_W-1:0] IDX_ONE   = INDEX_W'(1'b1);

    ov7670_state_e      state_r, state_s;
    logic [23:0]        counter_r, counter_s;
    logic [INDEX_W-1:0] index_r, index_s;
    logic [15:0]        command_r, command_s;
    logic               send_r, send_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [15:0]        rom_data_s;

    ov7670_config_rom #(
        .INDEX_W (INDEX_W),
        .ROM_SEL (ROM_SEL)
    ) u_rom (
        .addr (index_r),
        .data (rom_data_s)
    );

    // State and output registers; outputs change together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= POWERUP;
            counter_r <= 24'd0;
            index_r   <= '0;
            command_r <= 16'h0000;
            send_r    <= 1'b0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            counter_r <= counter_s;
            index_r   <= index_s;
            command_r <= command_s;
            send_r    <= send_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Next-state and next-output decode; entering DONE loads the done outputs
    // on the same edge so they are valid from the first DONE cycle.
    always_comb begin
        state_s   = state_r;
        counter_s = counter_r;
        index_s   = index_r;
        command_s = command_r;
        send_s    = send_r;
        busy_s    = busy_r;
        done_s    = done_r;
        case (state_r)
            POWERUP: begin
                if (counter_r == PU_LAST) begin
                    counter_s = 24'd0;
                    state_s   = FETCH;
                end else begin
                    counter_s = counter_r + 24'd1;
                end
            end
            FETCH: begin
                if (rom_data_s == OV7670_CMD_END) begin
                    state_s   = DONE;
                    command_s = OV7670_CMD_END;
                    send_s    = 1'b0;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                end else begin
                    state_s   = SEND;
                    command_s = rom_data_s;
                    send_s    = 1'b1;
                end
            end
            SEND: begin
                if (taken) begin
                    send_s = 1'b0;
                    if (command_r == OV7670_CMD_SWRESET) begin
                        state_s   = DELAY;
                        counter_s = 24'd0;
                    end else if (index_r == IDX_MAX) begin
                        // Last slot held a real command: stop rather than wrap.
                        state_s   = DONE;
                        command_s = OV7670_CMD_END;
                        busy_s    = 1'b0;
                        done_s    = 1'b1;
                    end else begin
                        index_s = index_r + IDX_ONE;
                        state_s = FETCH;
                    end
                end else begin
                    send_s = 1'b1;
                end
            end
            DELAY: begin
                if (counter_r == SR_LAST) begin
                    counter_s = 24'd0;
                    if (index_r == IDX_MAX) begin
                        state_s   = DONE;
                        command_s = OV7670_CMD_END;
                        busy_s    = 1'b0;
                        done_s    = 1'b1;
                    end else begin
                        index_s = index_r + IDX_ONE;
                        state_s = FETCH;
                    end
                end else begin
                    counter_s = counter_r + 24'd1;
                end
            end
            DONE: begin
                command_s = OV7670_CMD_END;
                send_s    = 1'b0;
                if (resend) begin
                    // Re-run skips the power-up wait: the sensor is already up.
                    index_s = '0;
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    state_s = FETCH;
                end else begin
                    busy_s = 1'b0;
                    done_s = 1'b1;
                end
            end
            default: begin
                state_s   = POWERUP;
                counter_s = 24'd0;
                index_s   = '0;
                command_s = 16'h0000;
                send_s    = 1'b0;
                busy_s    = 1'b1;
                done_s    = 1'b0;
            end
        endcase
    end

    assign command = command_r;
    assign send    = send_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign index   = index_r;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ov7670_config_sequencer
// Directed bench: instance a uses the terminated short table with an 8-bit
// index, instance b uses a four-entry table without terminator and a 2-bit
// index. Inputs change on the falling edge, outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_ov7670_config_sequencer;

    logic        clk;
    logic        a_reset, a_resend, a_taken;
    logic [15:0] a_command;
    logic        a_send, a_busy, a_done;
    logic [7:0]  a_index;
    logic        b_reset, b_resend, b_taken;
    logic [15:0] b_command;
    logic        b_send, b_busy, b_done;
    logic [1:0]  b_index;

    int n_checks;
    int n_pass;

    ov7670_config_sequencer #(
        .POWERUP_CYCLES (10),
        .SWRESET_CYCLES (20),
        .INDEX_W        (8),
        .ROM_SEL        (1)
    ) dut_a (
        .clk     (clk),
        .reset   (a_reset),
        .resend  (a_resend),
        .taken   (a_taken),
        .command (a_command),
        .send    (a_send),
        .busy    (a_busy),
        .done    (a_done),
        .index   (a_index)
    );

    ov7670_config_sequencer #(
        .POWERUP_CYCLES (10),
        .SWRESET_CYCLES (20),
        .INDEX_W        (2),
        .ROM_SEL        (2)
    ) dut_b (
        .clk     (clk),
        .reset   (b_reset),
        .resend  (b_resend),
        .taken   (b_taken),
        .command (b_command),
        .send    (b_send),
        .busy    (b_busy),
        .done    (b_done),
        .index   (b_index)
    );

    // 50 MHz clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_a_reset_vals(input string tag);
        check_eq({tag, " command"}, 32'(a_command), 32'h0000);
        check_eq({tag, " send"},    32'(a_send),    32'd0);
        check_eq({tag, " busy"},    32'(a_busy),    32'd1);
        check_eq({tag, " done"},    32'(a_done),    32'd0);
        check_eq({tag, " index"},   32'(a_index),   32'd0);
    endtask

    task automatic pulse_a_taken();
        a_taken = 1'b1;
        tick();
        a_taken = 1'b0;
    endtask

    logic [15:0] b_exp [4];
    bit          ok;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        a_reset = 1'b1; a_resend = 1'b0; a_taken = 1'b0;
        b_reset = 1'b1; b_resend = 1'b0; b_taken = 1'b0;
        b_exp[0] = 16'h1280; b_exp[1] = 16'h1204;
        b_exp[2] = 16'h4010; b_exp[3] = 16'h3A04;
        @(negedge clk);
        tick();
        tick();
        check_a_reset_vals("reset");

        // 1: power-up wait, then first command held until taken
        a_reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq($sformatf("powerup send c%0d", i), 32'(a_send), 32'd0);
        end
        tick();
        check_eq("first send", 32'(a_send), 32'd1);
        check_eq("first cmd", 32'(a_command), 32'h1280);
        for (int i = 0; i < 3; i++) tick();
        check_eq("hold send", 32'(a_send), 32'd1);
        check_eq("hold cmd", 32'(a_command), 32'h1280);
        check_eq("hold busy", 32'(a_busy), 32'd1);

        // 1b: resend during SEND is ignored
        a_resend = 1'b1;
        tick();
        a_resend = 1'b0;
        check_eq("resend@send send", 32'(a_send), 32'd1);
        check_eq("resend@send cmd", 32'(a_command), 32'h1280);
        check_eq("resend@send index", 32'(a_index), 32'd0);

        // 2: soft-reset settle delay
        pulse_a_taken();
        for (int i = 0; i <= 20; i++) begin
            check_eq($sformatf("swreset delay send c%0d", i), 32'(a_send), 32'd0);
            tick();
        end
        check_eq("post-delay send", 32'(a_send), 32'd1);
        check_eq("post-delay cmd", 32'(a_command), 32'h1204);
        check_eq("post-delay index", 32'(a_index), 32'd1);

        // 3: two-cycle turnaround, then terminator
        pulse_a_taken();
        check_eq("t1204 send drop", 32'(a_send), 32'd0);
        tick();
        check_eq("t1204 next send", 32'(a_send), 32'd1);
        check_eq("t1204 next cmd", 32'(a_command), 32'h4010);
        check_eq("t1204 next index", 32'(a_index), 32'd2);
        pulse_a_taken();
        check_eq("t4010 send drop", 32'(a_send), 32'd0);
        check_eq("t4010 done early", 32'(a_done), 32'd0);
        tick();
        check_eq("end done", 32'(a_done), 32'd1);
        check_eq("end busy", 32'(a_busy), 32'd0);
        check_eq("end cmd", 32'(a_command), 32'hFFFF);
        check_eq("end send", 32'(a_send), 32'd0);
        check_eq("end index", 32'(a_index), 32'd3);
        tick();
        check_eq("end hold done", 32'(a_done), 32'd1);

        // 4: re-run without power-up wait
        a_resend = 1'b1;
        tick();
        a_resend = 1'b0;
        check_eq("resend index", 32'(a_index), 32'd0);
        check_eq("resend done", 32'(a_done), 32'd0);
        check_eq("resend busy", 32'(a_busy), 32'd1);
        check_eq("resend send early", 32'(a_send), 32'd0);
        tick();
        check_eq("resend send", 32'(a_send), 32'd1);
        check_eq("resend cmd", 32'(a_command), 32'h1280);

        // 5: reset during DELAY with a simultaneous taken
        pulse_a_taken();
        for (int i = 0; i < 5; i++) tick();
        a_reset = 1'b1;
        a_taken = 1'b1;
        tick();
        a_reset = 1'b0;
        a_taken = 1'b0;
        check_a_reset_vals("reset@delay");
        a_taken = 1'b1; // stray taken in POWERUP must be ignored
        for (int i = 1; i <= 10; i++) begin
            tick();
            a_taken = 1'b0;
            check_eq($sformatf("rerun powerup send c%0d", i), 32'(a_send), 32'd0);
        end
        tick();
        check_eq("rerun send", 32'(a_send), 32'd1);
        check_eq("rerun cmd", 32'(a_command), 32'h1280);
        check_eq("rerun index", 32'(a_index), 32'd0);

        // 6: unterminated table on a 2-bit index stops at the last slot
        b_reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
                tick();
                ok = b_send;
            end
            check_eq($sformatf("wrap wait send %0d", k), 32'(ok), 32'd1);
            check_eq($sformatf("wrap cmd %0d", k), 32'(b_command), 32'(b_exp[k]));
            check_eq($sformatf("wrap index %0d", k), 32'(b_index), 32'(k));
            b_taken = 1'b1;
            tick();
            b_taken = 1'b0;
        end
        check_eq("wrap done", 32'(b_done), 32'd1);
        check_eq("wrap busy", 32'(b_busy), 32'd0);
        check_eq("wrap cmd end", 32'(b_command), 32'hFFFF);
        check_eq("wrap index", 32'(b_index), 32'd3);
        for (int i = 0; i < 3; i++) tick();
        check_eq("wrap index hold", 32'(b_index), 32'd3);
        check_eq("wrap done hold", 32'(b_done), 32'd1);
        check_eq("wrap send hold", 32'(b_send), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
